// File: rtl/tile_spawn_scheduler_if.sv
`default_nettype none
// ============================================================================
// tile_spawn_scheduler_if : level control, spawn handshake and status bundle
// Revision : 1.0
// ============================================================================
interface tile_spawn_scheduler_if #(
  parameter int NUM_TILES = 8
);
  logic                 levelGo;
  logic                 oneTensSec;
  logic [NUM_TILES-1:0] spawnReq;
  logic [NUM_TILES-1:0] tileExceed;
  logic [NUM_TILES-1:0] spawnGrant;
  logic                 startofLevel;
  logic                 endLevel;
  logic [4:0]           activeCount;
  logic [11:0]          levelTimeLeft;
  logic [7:0]           passedCount;
  logic                 levelDone;

  modport master (
    output levelGo, oneTensSec, spawnReq, tileExceed,
    input  spawnGrant, startofLevel, endLevel, activeCount,
           levelTimeLeft, passedCount, levelDone
  );

  modport slave (
    input  levelGo, oneTensSec, spawnReq, tileExceed,
    output spawnGrant, startofLevel, endLevel, activeCount,
           levelTimeLeft, passedCount, levelDone
  );
endinterface
`default_nettype wire

// File: rtl/tile_spawn_scheduler.sv
`default_nettype none
// ============================================================================
// tile_spawn_scheduler : level sequencer with round-robin, rate-limited spawns
// Revision : 1.0
// ============================================================================
module tile_spawn_scheduler #(
  parameter int NUM_TILES    = 8,
  parameter int MAX_ACTIVE   = 3,
  parameter int LEVEL_TENTHS = 600,
  parameter int GAP_TENTHS   = 5
) (
  input wire clk,
  input wire reset,
  tile_spawn_scheduler_if.slave bus
);
  localparam int PW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_END   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [4:0]  c_MAX_ACTIVE = 5'(MAX_ACTIVE);
  localparam logic [11:0] c_LEVEL      = 12'(LEVEL_TENTHS);
  localparam logic [7:0]  c_GAP        = 8'(GAP_TENTHS);
  localparam logic [PW:0] c_N          = (PW+1)'(NUM_TILES);
  localparam logic [PW-1:0] c_LAST     = PW'(NUM_TILES - 1);

  logic [2:0]           r_state;
  logic [NUM_TILES-1:0] r_active;
  logic [NUM_TILES-1:0] r_grant;
  logic [PW-1:0]        r_ptr;
  logic [7:0]           r_gap;
  logic [7:0]           r_passed;
  logic [11:0]          r_time;
  logic [4:0]           r_count;
  logic                 r_start;
  logic                 r_end;
  logic                 r_done;

  logic [NUM_TILES-1:0]   w_cand;
  logic [2*NUM_TILES-1:0] w_dbl;
  logic [NUM_TILES-1:0]   w_rot;
  logic [NUM_TILES-1:0]   w_grant_vec;
  logic [NUM_TILES-1:0]   w_active_next;
  logic [NUM_TILES-1:0]   w_hits;
  logic [PW-1:0]          w_off;
  logic [PW:0]            w_sum;
  logic [PW-1:0]          w_pick;
  logic [PW-1:0]          w_ptr_next;
  logic                   w_found;
  logic                   w_grant_ok;
  logic [4:0]             w_count_next;
  logic [4:0]             w_hit_cnt;
  logic [8:0]             w_passed_sum;
  logic [7:0]             w_passed_next;
  logic                   w_expire;

  // Rotate candidates so the RR pointer lands on bit 0, then take the lowest set bit.
  always_comb begin
    w_cand  = bus.spawnReq & ~r_active;
    w_dbl   = {w_cand, w_cand} >> r_ptr;
    w_rot   = w_dbl[NUM_TILES-1:0];
    w_found = 1'b0;
    w_off   = '0;
    for (int k = 0; k < NUM_TILES; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_off   = PW'(k);
      end
    end
    w_sum      = {1'b0, r_ptr} + {1'b0, w_off};
    w_pick     = (w_sum >= c_N) ? PW'(w_sum - c_N) : w_sum[PW-1:0];
    w_ptr_next = (w_pick == c_LAST) ? '0 : w_pick + PW'(1);
    w_grant_ok = (r_state == S_RUN) && (r_count < c_MAX_ACTIVE) &&
                 (r_gap == 8'd0) && w_found;
    w_grant_vec = w_grant_ok ? (NUM_TILES'(1) << w_pick) : '0;
  end

  always_comb begin
    w_hits        = bus.tileExceed & r_active;
    w_hit_cnt     = 5'($countones(w_hits));
    w_active_next = (r_active & ~bus.tileExceed) | w_grant_vec;
    w_count_next  = 5'($countones(w_active_next));
    w_passed_sum  = {1'b0, r_passed} + {4'b0, w_hit_cnt};
    w_passed_next = w_passed_sum[8] ? 8'hFF : w_passed_sum[7:0];
    w_expire      = (r_time == 12'd0) || ((r_time == 12'd1) && bus.oneTensSec);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_active <= '0;
      r_grant  <= '0;
      r_ptr    <= '0;
      r_gap    <= '0;
      r_passed <= '0;
      r_time   <= '0;
      r_count  <= '0;
      r_start  <= 1'b0;
      r_end    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_start  <= 1'b0;
      r_end    <= 1'b0;
      r_grant  <= w_grant_vec;
      r_active <= w_active_next;
      r_count  <= w_count_next;
      r_passed <= w_passed_next;
      if (w_grant_ok) begin
        r_gap <= c_GAP;
        r_ptr <= w_ptr_next;
      end else if (bus.oneTensSec && (r_gap != 8'd0)) begin
        r_gap <= r_gap - 8'd1;
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.levelGo) begin
            r_state  <= S_START;
            r_start  <= 1'b1;
            r_done   <= 1'b0;
            r_time   <= c_LEVEL;
            r_passed <= '0;
            r_active <= '0;
            r_count  <= '0;
            r_gap    <= '0;
            r_ptr    <= '0;
          end
        end
        S_START: r_state <= S_RUN;
        S_RUN: begin
          if (bus.oneTensSec && (r_time != 12'd0)) begin
            r_time <= r_time - 12'd1;
          end
          if (w_expire) begin
            r_state <= S_END;
            r_end   <= 1'b1;
          end
        end
        S_END: begin
          r_state  <= S_DONE;
          r_done   <= 1'b1;
          r_active <= '0;
          r_count  <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.spawnGrant    = r_grant;
  assign bus.startofLevel  = r_start;
  assign bus.endLevel      = r_end;
  assign bus.activeCount   = r_count;
  assign bus.levelTimeLeft = r_time;
  assign bus.passedCount   = r_passed;
  assign bus.levelDone     = r_done;
endmodule
`default_nettype wire
